// File: rtl/operand_fetch.sv
// operand_fetch: fetches operands from the regfile for execute.
// Stalls on read-after-write hazards and bypasses a writeback that lands in the same cycle.
module operand_fetch #(
   parameter int XLEN = 32,
   parameter int AW = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   in_rs1,
   input  logic [AW-1:0]   in_rs2,
   input  logic            in_use_rs1,
   input  logic            in_use_rs2,
   input  logic [AW-1:0]   in_rd,
   input  logic            in_rd_wen,
   output logic [AW-1:0]   rf_rd_addr_1,
   output logic [AW-1:0]   rf_rd_addr_2,
   input  logic [XLEN-1:0] rf_rd_data_1,
   input  logic [XLEN-1:0] rf_rd_data_2,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            wb_enable,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [AW-1:0]   out_rd,
   output logic            out_rd_wen,
   output logic            stall
);
   localparam int NR = 2**AW;
   localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, HOLD = 2'd2;
   logic [1:0]      state, next_state;
   logic [AW-1:0]   rs1, rs2, rd;
   logic            use1, use2, rd_wen;
   logic [NR-1:0]   busy, set_mask, clr_mask;
   logic            byp1, byp2, hz1, hz2, in_fire, out_fire;
   logic [XLEN-1:0] op1, op2;
   always_comb begin
      in_ready     = state == IDLE || (state == HOLD && out_ready);
      out_valid    = state == HOLD;
      in_fire      = in_valid && in_ready;
      out_fire     = out_valid && out_ready && !flush;
      rf_rd_addr_1 = (state == READ && use1) ? rs1 : '0;
      rf_rd_addr_2 = (state == READ && use2) ? rs2 : '0;
      byp1         = wb_enable && wb_addr == rs1;
      byp2         = wb_enable && wb_addr == rs2;
      hz1          = use1 && rs1 != '0 && busy[rs1] && !byp1;
      hz2          = use2 && rs2 != '0 && busy[rs2] && !byp2;
      stall        = state == READ && (hz1 || hz2);
      op1          = (!use1 || rs1 == '0) ? '0 : byp1 ? wb_data : rf_rd_data_1;
      op2          = (!use2 || rs2 == '0) ? '0 : byp2 ? wb_data : rf_rd_data_2;
      // set after clear so a newer producer wins over an older writeback
      set_mask     = (out_fire && rd_wen && rd != '0) ? NR'(1) << rd : '0;
      clr_mask     = (wb_enable && wb_addr != '0) ? NR'(1) << wb_addr : '0;
      next_state   = flush ? IDLE :
                     state == IDLE ? (in_fire ? READ : IDLE) :
                     state == READ ? (stall ? READ : HOLD) :
                     state == HOLD ? (out_fire ? (in_fire ? READ : IDLE) : HOLD) : IDLE;
      out_rd       = rd;
      out_rd_wen   = rd_wen;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         busy         <= '0;
         rs1          <= '0;
         rs2          <= '0;
         rd           <= '0;
         use1         <= 1'b0;
         use2         <= 1'b0;
         rd_wen       <= 1'b0;
         out_rs1_data <= '0;
         out_rs2_data <= '0;
      end else begin
         state <= next_state;
         busy  <= (busy & ~clr_mask) | set_mask;
         if (in_fire && !flush) begin
            rs1    <= in_rs1;
            rs2    <= in_rs2;
            use1   <= in_use_rs1;
            use2   <= in_use_rs2;
            rd     <= in_rd;
            rd_wen <= in_rd_wen;
         end
         if (state == READ && !stall && !flush) begin
            out_rs1_data <= op1;
            out_rs2_data <= op2;
         end
      end
   end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed checks of operand_fetch against a small regfile model.
module tb_operand_fetch;
   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, in_use_rs1, in_use_rs2, in_rd_wen;
   logic [4:0]  in_rs1, in_rs2, in_rd, rf_rd_addr_1, rf_rd_addr_2, wb_addr, out_rd;
   logic [31:0] rf_rd_data_1, rf_rd_data_2, wb_data, out_rs1_data, out_rs2_data;
   logic        wb_enable, out_valid, out_ready, out_rd_wen, stall;
   logic [31:0] rf [32];
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   operand_fetch dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
      .in_rd(in_rd), .in_rd_wen(in_rd_wen), .rf_rd_addr_1(rf_rd_addr_1), .rf_rd_addr_2(rf_rd_addr_2),
      .rf_rd_data_1(rf_rd_data_1), .rf_rd_data_2(rf_rd_data_2), .wb_addr(wb_addr), .wb_data(wb_data),
      .wb_enable(wb_enable), .out_valid(out_valid), .out_ready(out_ready), .out_rs1_data(out_rs1_data),
      .out_rs2_data(out_rs2_data), .out_rd(out_rd), .out_rd_wen(out_rd_wen), .stall(stall)
   );

   assign rf_rd_data_1 = rf[rf_rd_addr_1];
   assign rf_rd_data_2 = rf[rf_rd_addr_2];
   always @(posedge clk) if (wb_enable && wb_addr != 5'd0) rf[wb_addr] <= wb_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                        input logic [4:0] d, input logic w);
      in_valid = 1'b1; in_rs1 = r1; in_rs2 = r2; in_use_rs1 = u1; in_use_rs2 = u2;
      in_rd = d; in_rd_wen = w;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      rf[5] = 32'h11;
      rf[6] = 32'h22;
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      wb_enable = 1'b0; wb_addr = '0; wb_data = '0;
      issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      in_valid = 1'b0;
      tick; tick;
      reset = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_stall", stall, 0);
      chk("rst_data1", out_rs1_data, 0);
      chk("rst_addr1", rf_rd_addr_1, 0);
      chk("rst_busy", dut.busy, 0);
      // basic read of x5/x6
      issue(5'd5, 5'd6, 1'b1, 1'b1, 5'd3, 1'b0);
      tick;
      in_valid = 1'b0;
      chk("read_addr1", rf_rd_addr_1, 5);
      chk("read_addr2", rf_rd_addr_2, 6);
      chk("read_valid", out_valid, 0);
      tick;
      chk("basic_valid", out_valid, 1);
      chk("basic_op1", out_rs1_data, 32'h11);
      chk("basic_op2", out_rs2_data, 32'h22);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("basic_idle_valid", out_valid, 0);
      chk("basic_idle_ready", in_ready, 1);
      // producer of x7, then a RAW reader resolved by bypass
      issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1);
      tick;
      in_valid = 1'b0;
      tick;
      chk("prod_rd", out_rd, 7);
      chk("prod_wen", out_rd_wen, 1);
      chk("prod_op1", out_rs1_data, 0);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("busy7_set", dut.busy[7], 1);
      issue(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
      tick;
      in_valid = 1'b0;
      chk("raw_stall_a", stall, 1);
      tick;
      chk("raw_stall_b", stall, 1);
      chk("raw_no_valid", out_valid, 0);
      wb_enable = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD;
      #1;
      chk("raw_stall_clear", stall, 0);
      tick;
      wb_enable = 1'b0;
      chk("bypass_valid", out_valid, 1);
      chk("bypass_op1", out_rs1_data, 32'hDEAD);
      chk("busy7_clear", dut.busy[7], 0);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      // x0 sources with a writeback to x0
      issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
      tick;
      in_valid = 1'b0;
      wb_enable = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
      #1;
      chk("x0_stall", stall, 0);
      tick;
      wb_enable = 1'b0;
      chk("x0_op1", out_rs1_data, 0);
      chk("x0_op2", out_rs2_data, 0);
      chk("x0_busy", dut.busy[0], 0);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      // backpressure in HOLD, then back-to-back with set/clear collision on x9
      issue(5'd5, 5'd6, 1'b1, 1'b1, 5'd9, 1'b1);
      tick;
      in_valid = 1'b0;
      tick;
      for (int i = 0; i < 4; i++) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_op1", out_rs1_data, 32'h11);
         chk("hold_op2", out_rs2_data, 32'h22);
         chk("hold_rd", out_rd, 9);
         chk("hold_in_ready", in_ready, 0);
         tick;
      end
      out_ready = 1'b1;
      issue(5'd6, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
      wb_enable = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
      #1;
      chk("b2b_in_ready", in_ready, 1);
      tick;
      in_valid = 1'b0; out_ready = 1'b0; wb_enable = 1'b0;
      chk("b2b_gap", out_valid, 0);
      chk("busy9_set_wins", dut.busy[9], 1);
      tick;
      chk("b2b_valid", out_valid, 1);
      chk("b2b_op1", out_rs1_data, 32'h22);
      chk("b2b_op2", out_rs2_data, 32'h11);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      // reader of x9 stalls, then flush
      issue(5'd0, 5'd9, 1'b0, 1'b1, 5'd0, 1'b0);
      tick;
      in_valid = 1'b0;
      chk("x9_stall", stall, 1);
      chk("x9_addr1_unused", rf_rd_addr_1, 0);
      chk("x9_addr2", rf_rd_addr_2, 9);
      tick;
      chk("x9_stall_b", stall, 1);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("flush_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 1);
      chk("flush_stall", stall, 0);
      chk("flush_busy9", dut.busy[9], 1);
      issue(5'd0, 5'd9, 1'b0, 1'b1, 5'd0, 1'b0);
      flush = 1'b1;
      tick;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_wins_ready", in_ready, 1);
      chk("flush_wins_addr2", rf_rd_addr_2, 0);
      // reset mid-stall
      issue(5'd0, 5'd9, 1'b0, 1'b1, 5'd0, 1'b0);
      tick;
      in_valid = 1'b0;
      chk("pre_reset_stall", stall, 1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("reset_busy", dut.busy, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_stall", stall, 0);
      chk("reset_valid", out_valid, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
